vram_snoop: RTL and testbench

- Shadow capture of game-side PPU VRAM writes for the save-state path.
- It is the reverse direction of the OS VRAM window. There, the OS writes the shadow and the PPU reads it. Here, the block snoops game CPU writes to $2000/$2005/$2006/$2007, tracks the PPU t/v/w address state, and stores nametable and palette bytes into internal RAM.
- The OS later reads the RAM and the tracked state back through a register window at $41xx.

---
 rtl/snoop_pkg.sv | 20 ++
 rtl/ppu_addr_track.sv | 78 +++++++
 rtl/ram_dp_sv.sv | 19 +
 rtl/vram_snoop.sv | 115 +++++++++++
 tb/tb_vram_snoop.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/snoop_pkg.sv
// snoop_pkg: shared PPU register indices, readback offsets and VRAM address boundaries
package snoop_pkg;
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_SCROLL = 3'd5;
    localparam logic [2:0] REG_ADDR   = 3'd6;
    localparam logic [2:0] REG_DATA   = 3'd7;
    localparam logic [2:0] RB_LO   = 3'd0;
    localparam logic [2:0] RB_HI   = 3'd1;
    localparam logic [2:0] RB_DATA = 3'd2;
    localparam logic [2:0] RB_STAT = 3'd3;
    localparam logic [2:0] RB_V_LO = 3'd4;
    localparam logic [2:0] RB_V_HI = 3'd5;
    localparam logic [2:0] RB_T_LO = 3'd6;
    localparam logic [2:0] RB_T_HI = 3'd7;
    localparam logic [13:0] NTB_BASE = 14'h2000;
    localparam logic [13:0] NTB_END  = 14'h3EFF;
    localparam logic [13:0] PAL_BASE = 14'h3F00;
    localparam logic [12:0] RB_PAL   = 13'h1000;
endpackage

// File: rtl/ppu_addr_track.sv
// ppu_addr_track: mirrors PPU t/v/w/ctrl_inc32 from snooped register accesses and emits store strobes
// Ports: clk, rst_n; ev (one-clk snooped PPU access), rw, idx, d; t/v/w/inc32 state;
//        st_ntb/st_addr nametable store, st_pal/st_pal_addr palette store.
module ppu_addr_track import snoop_pkg::*; #(
    parameter int NTB_AW = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ev,
    input  logic              rw,
    input  logic [2:0]        idx,
    input  logic [7:0]        d,
    output logic [14:0]       t,
    output logic [14:0]       v,
    output logic              w,
    output logic              inc32,
    output logic              st_ntb,
    output logic [NTB_AW-1:0] st_addr,
    output logic              st_pal,
    output logic [4:0]        st_pal_addr
);
    logic [14:0] t_q, t_d, v_q, v_d;
    logic        w_q, w_d, inc32_q, inc32_d;
    logic        wr_ev, data_ev;
    assign wr_ev   = ev & ~rw;
    assign data_ev = ev & (idx == REG_DATA);
    always_comb begin
        t_d = t_q;
        v_d = v_q;
        w_d = w_q;
        inc32_d = inc32_q;
        if (wr_ev && idx == REG_CTRL) begin
            t_d[11:10] = d[1:0];
            inc32_d = d[2];
        end
        if (wr_ev && idx == REG_SCROLL) begin
            if (!w_q) t_d[4:0] = d[7:3];
            else begin
                t_d[14:12] = d[2:0];
                t_d[9:5] = d[7:3];
            end
            w_d = ~w_q;
        end
        if (wr_ev && idx == REG_ADDR) begin
            if (!w_q) t_d[14:8] = {1'b0, d[5:0]};
            else begin
                t_d[7:0] = d;
                v_d = {t_q[14:8], d};
            end
            w_d = ~w_q;
        end
        if (ev && rw && idx == REG_STATUS) w_d = 1'b0;
        if (data_ev) v_d = v_q + (inc32_q ? 15'd32 : 15'd1);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q <= '0;
            v_q <= '0;
            w_q <= 1'b0;
            inc32_q <= 1'b0;
        end else begin
            t_q <= t_d;
            v_q <= v_d;
            w_q <= w_d;
            inc32_q <= inc32_d;
        end
    end
    // Stores use v before this access's increment.
    assign st_ntb = data_ev & ~rw & (v_q[13:0] >= NTB_BASE) & (v_q[13:0] <= NTB_END);
    assign st_pal = data_ev & ~rw & (v_q[13:0] >= PAL_BASE);
    assign st_addr = v_q[NTB_AW-1:0];
    // $3F10/14/18/1C share storage with the backdrop entries $3F00/04/08/0C.
    assign st_pal_addr = (v_q[4] && v_q[1:0] == 2'b00) ? {1'b0, v_q[3:0]} : v_q[4:0];
    assign t = t_q;
    assign v = v_q;
    assign w = w_q;
    assign inc32 = inc32_q;
endmodule

// File: rtl/ram_dp_sv.sv
// ram_dp_sv: simple dual-port RAM, port A write, port B registered read (old data on collision)
// Ports: clk; we/waddr/wdata write port; raddr/rdata registered read port.
module ram_dp_sv #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/vram_snoop.sv
// vram_snoop: shadows game-side PPU VRAM writes into RAM and exposes them via a $41xx readback window
// Ports: clk, rst_n; m2/cpu_addr/cpu_data/cpu_rw CPU bus (m2 asynchronous);
//        os_act selects readback over snoop; cpu_do/cpu_oe readback data and drive enable.
module vram_snoop import snoop_pkg::*; #(
    parameter logic [7:0] REG_BASE = 8'h10,
    parameter int         NTB_AW   = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m2,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_rw,
    input  logic        os_act,
    output logic [7:0]  cpu_do,
    output logic        cpu_oe
);
    logic        m2_meta_q, m2_s_q, m2_s_dly_q;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d, prefetch_q, prefetch_d;
    logic        rw_q, rw_d, fetch_q, fetch_d;
    logic [12:0] rb_addr_q, rb_addr_d;
    logic [1:0]  sel_q, sel_d;
    logic        evt, cap_rb, live_rb;
    logic [7:0]  cap_off, live_off, ntb_rd, pal_rd;
    logic [14:0] t, v;
    logic        w, inc32, st_ntb, st_pal;
    logic [NTB_AW-1:0] st_addr;
    logic [4:0]  st_pal_addr;
    assign evt      = m2_s_dly_q & ~m2_s_q;
    assign cap_off  = addr_q[7:0] - REG_BASE;
    assign live_off = cpu_addr[7:0] - REG_BASE;
    assign cap_rb   = os_act && addr_q[15:8] == 8'h41 && cap_off < 8'd8;
    assign live_rb  = os_act && cpu_addr[15:8] == 8'h41 && live_off < 8'd8;
    assign cpu_oe   = live_rb & cpu_rw;
    ppu_addr_track #(.NTB_AW(NTB_AW)) u_track (
        .clk(clk), .rst_n(rst_n),
        .ev(evt & ~os_act & (addr_q[15:13] == 3'b001)),
        .rw(rw_q), .idx(addr_q[2:0]), .d(data_q),
        .t(t), .v(v), .w(w), .inc32(inc32),
        .st_ntb(st_ntb), .st_addr(st_addr), .st_pal(st_pal), .st_pal_addr(st_pal_addr)
    );
    // Port B always reads at rb_addr_d so a fetch issued at the bus event lands in prefetch one clk later.
    ram_dp_sv #(.AW(NTB_AW), .DW(8)) u_ntb (
        .clk(clk), .we(st_ntb), .waddr(st_addr), .wdata(data_q),
        .raddr(rb_addr_d[NTB_AW-1:0]), .rdata(ntb_rd)
    );
    ram_dp_sv #(.AW(5), .DW(8)) u_pal (
        .clk(clk), .we(st_pal), .waddr(st_pal_addr), .wdata(data_q),
        .raddr(rb_addr_d[4:0]), .rdata(pal_rd)
    );
    always_comb begin
        addr_d = m2_s_q ? cpu_addr : addr_q;
        data_d = m2_s_q ? cpu_data : data_q;
        rw_d   = m2_s_q ? cpu_rw : rw_q;
        rb_addr_d = rb_addr_q;
        fetch_d = 1'b0;
        if (evt && cap_rb && !rw_q && cap_off[2:0] == RB_LO) begin
            rb_addr_d[7:0] = data_q;
            fetch_d = 1'b1;
        end
        if (evt && cap_rb && !rw_q && cap_off[2:0] == RB_HI) begin
            rb_addr_d[12:8] = data_q[4:0];
            fetch_d = 1'b1;
        end
        if (evt && cap_rb && rw_q && cap_off[2:0] == RB_DATA) begin
            rb_addr_d = rb_addr_q + 13'd1;
            fetch_d = 1'b1;
        end
        // 1 = nametable, 2 = palette, 0 = unmapped (reads $00)
        sel_d = rb_addr_d < RB_PAL ? 2'd1 : rb_addr_d[12:5] == RB_PAL[12:5] ? 2'd2 : 2'd0;
        prefetch_d = !fetch_q ? prefetch_q : sel_q == 2'd1 ? ntb_rd : sel_q == 2'd2 ? pal_rd : 8'h00;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m2_meta_q <= 1'b0;
            m2_s_q <= 1'b0;
            m2_s_dly_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            rw_q <= 1'b1;
            rb_addr_q <= '0;
            fetch_q <= 1'b0;
            sel_q <= '0;
            prefetch_q <= 8'h00;
        end else begin
            m2_meta_q <= m2;
            m2_s_q <= m2_meta_q;
            m2_s_dly_q <= m2_s_q;
            addr_q <= addr_d;
            data_q <= data_d;
            rw_q <= rw_d;
            rb_addr_q <= rb_addr_d;
            fetch_q <= fetch_d;
            sel_q <= sel_d;
            prefetch_q <= prefetch_d;
        end
    end
    always_comb begin
        cpu_do = 8'h00;
        if (cpu_oe) begin
            case (live_off[2:0])
                RB_LO:   cpu_do = rb_addr_q[7:0];
                RB_HI:   cpu_do = {3'b000, rb_addr_q[12:8]};
                RB_DATA: cpu_do = prefetch_q;
                RB_STAT: cpu_do = {w, inc32, 6'b000000};
                RB_V_LO: cpu_do = v[7:0];
                RB_V_HI: cpu_do = {1'b0, v[14:8]};
                RB_T_LO: cpu_do = t[7:0];
                RB_T_HI: cpu_do = {1'b0, t[14:8]};
                default: cpu_do = 8'h00;
            endcase
        end
    end
endmodule

// File: tb/tb_vram_snoop.sv
// tb_vram_snoop: scoreboard bench driving CPU bus cycles and checking readback through the $41xx window
module tb_vram_snoop;
    logic        clk = 1'b0, rst_n = 1'b0, m2 = 1'b0, cpu_rw = 1'b1, os_act = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_data = 8'h00;
    logic [7:0]  cpu_do;
    logic        cpu_oe;
    int          tests = 0, fails = 0;
    logic [7:0]  exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    vram_snoop #(.REG_BASE(8'h10), .NTB_AW(12)) dut (
        .clk(clk), .rst_n(rst_n), .m2(m2), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_rw(cpu_rw), .os_act(os_act), .cpu_do(cpu_do), .cpu_oe(cpu_oe)
    );

    // Monitor: the CPU latches read data at the M2 fall; compare against the queued expectation.
    always @(negedge m2) begin : mon
        logic [7:0] e;
        string n;
        if (cpu_oe) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_oe: got %02h, required no readback drive", cpu_do);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (cpu_do !== e) begin
                    fails++;
                    $display("FAIL %s: got %02h, required %02h", n, cpu_do, e);
                end
            end
        end
    end

    task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic rw, input logic os);
        @(posedge clk); #2;
        cpu_addr = a; cpu_data = d; cpu_rw = rw; os_act = os; m2 = 1'b1;
        repeat (4) @(posedge clk);
        #2 m2 = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus(a, d, 1'b0, 1'b0);
    endtask

    task automatic rd_ppu(input logic [15:0] a);
        bus(a, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic rbw(input logic [2:0] n, input logic [7:0] d);
        bus(16'h4110 + {13'd0, n}, d, 1'b0, 1'b1);
    endtask

    task automatic rbr(input logic [2:0] n, input logic [7:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        bus(16'h4110 + {13'd0, n}, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic setv(input logic [7:0] hi, input logic [7:0] lo);
        rd_ppu(16'h2002);
        wr(16'h2006, hi);
        wr(16'h2006, lo);
    endtask

    task automatic chkv(input logic [14:0] ev, input string nm);
        rbr(3'd4, ev[7:0], {nm, "_vlo"});
        rbr(3'd5, {1'b0, ev[14:8]}, {nm, "_vhi"});
    endtask

    task automatic chkmem(input logic [12:0] a, input logic [7:0] e, input string nm);
        rbw(3'd1, {3'b000, a[12:8]});
        rbw(3'd0, a[7:0]);
        rbr(3'd2, e, nm);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (cpu_oe !== 1'b0 || cpu_do !== 8'h00) begin
            fails++;
            $display("FAIL reset_out: got oe=%b do=%02h, required oe=0 do=00", cpu_oe, cpu_do);
        end
        rst_n = 1'b1;
        rbr(3'd3, 8'h00, "reset_stat");
        chkv(15'h0000, "reset_v");
        rbr(3'd7, 8'h00, "reset_thi");
        rbr(3'd2, 8'h00, "reset_prefetch");

        // address load and nametable store (through a $2008+ mirror for the data port)
        wr(16'h2006, 8'h21);
        wr(16'h2006, 8'h08);
        wr(16'h200F, 8'h5A);
        chkv(15'h2109, "load_v");
        rbr(3'd3, 8'h00, "load_stat");
        rbr(3'd6, 8'h08, "load_tlo");
        rbr(3'd7, 8'h21, "load_thi");
        chkmem(13'h0108, 8'h5A, "ntb_108");

        // 32-byte increment
        wr(16'h2000, 8'h04);
        setv(8'h23, 8'hC0);
        wr(16'h2007, 8'hA1);
        wr(16'h2007, 8'hA2);
        wr(16'h2007, 8'hA3);
        chkv(15'h2420, "inc32_v");
        rbr(3'd3, 8'h40, "inc32_stat");
        chkmem(13'h03C0, 8'hA1, "ntb_3c0");
        chkmem(13'h03E0, 8'hA2, "ntb_3e0");
        chkmem(13'h0400, 8'hA3, "ntb_400");
        wr(16'h2005, 8'h00);
        rbr(3'd3, 8'hC0, "scroll_w1");
        rd_ppu(16'h2002);
        rbr(3'd3, 8'h40, "status_clr_w");
        wr(16'h2000, 8'h00);

        // palette aliasing
        setv(8'h3F, 8'h10);
        wr(16'h2007, 8'h0F);
        wr(16'h2007, 8'h22);
        chkv(15'h3F12, "pal_v");
        chkmem(13'h1000, 8'h0F, "pal_alias_0");
        chkmem(13'h1011, 8'h22, "pal_11");
        chkmem(13'h1020, 8'h00, "rb_unmapped");

        // pattern area and wrap
        setv(8'h2F, 8'hFF);
        wr(16'h2007, 8'hC3);
        setv(8'h1F, 8'hFF);
        wr(16'h2007, 8'h99);
        chkv(15'h2000, "pat_v");
        chkmem(13'h0FFF, 8'hC3, "pat_nostore");
        rd_ppu(16'h2002);
        wr(16'h2005, 8'hF8);
        wr(16'h2005, 8'hFF);
        wr(16'h2000, 8'h03);
        wr(16'h2005, 8'hF8);
        wr(16'h2006, 8'hFF);
        chkv(15'h7FFF, "wrap_pre");
        rd_ppu(16'h2007);
        chkv(15'h0000, "wrap_v");
        wr(16'h2000, 8'h00);

        // readback auto-increment across the NTB/PAL boundary
        rbw(3'd1, 8'h0F);
        rbw(3'd0, 8'hFF);
        rbr(3'd2, 8'hC3, "autoinc_ntb");
        rbr(3'd2, 8'h0F, "autoinc_pal");
        rbr(3'd0, 8'h01, "autoinc_rblo");
        rbr(3'd1, 8'h10, "autoinc_rbhi");
        setv(8'h21, 8'h08);
        bus(16'h2007, 8'h77, 1'b0, 1'b1);
        chkv(15'h2108, "os_nosnoop_v");
        chkmem(13'h0108, 8'h5A, "os_nosnoop_ram");

        // asynchronous reset mid-sequence, with a nonzero prefetch pending
        rbw(3'd1, 8'h01);
        rbw(3'd0, 8'h08);
        wr(16'h2006, 8'h21);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        tests++;
        if (cpu_oe !== 1'b0) begin
            fails++;
            $display("FAIL midreset_oe: got %b, required 0", cpu_oe);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        rbr(3'd3, 8'h00, "midreset_stat");
        chkv(15'h0000, "midreset_v");
        rbr(3'd6, 8'h00, "midreset_tlo");
        rbr(3'd7, 8'h00, "midreset_thi");
        rbr(3'd2, 8'h00, "midreset_prefetch");

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL readback_drained: got %0d unserved reads, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
